// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: six-digit seven-segment scanner with debounced source select
// and a once-per-frame snapshot so a frame never mixes two values.
module seg_scan_ctrl #(
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_CYCLES = 20000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [5:0]  Switch,
    input  logic [31:0] PC,
    input  logic [31:0] Instr,
    input  logic [31:0] ALU_Result,
    input  logic [31:0] Mem_Data,
    output logic [7:0]  Segs,
    output logic [5:0]  En
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    // entry n (bits 8n+7:8n) is the active-low pattern for hex digit n, dp off
    localparam logic [127:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    logic [2:0]    r_sw_meta;
    logic [2:0]    r_sw_sync;
    logic [2:0]    r_sw_cand;
    logic [2:0]    r_sw_deb;
    logic [DW-1:0] r_deb_cnt;
    logic [PW-1:0] r_pre;
    logic [2:0]    r_dig;
    logic [23:0]   r_snap;
    logic          r_load;
    logic          w_pre_wrap;
    logic          w_frame_end;
    logic [31:0]   w_src;
    logic [23:0]   w_sel;
    logic [3:0]    w_nib;
    logic          w_unused;

    assign w_unused = ^Switch[5:3];

    always_comb begin
        w_pre_wrap  = r_pre == PW'(SCAN_DIV - 1);
        w_frame_end = w_pre_wrap && r_dig == 3'd5;
        w_src       = r_sw_deb[1] ? (r_sw_deb[0] ? Mem_Data : ALU_Result)
                                  : (r_sw_deb[0] ? Instr : PC);
        w_sel       = r_sw_deb[2] ? w_src[31:8] : w_src[23:0];
        w_nib       = 4'(r_snap >> {r_dig, 2'b00});
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_sw_cand <= '0;
            r_sw_deb  <= '0;
            r_deb_cnt <= '0;
            r_pre     <= '0;
            r_dig     <= '0;
            r_snap    <= '0;
            r_load    <= 1'b1;
            En        <= '1;
            Segs      <= '1;
        end else begin
            r_sw_meta <= Switch[2:0];
            r_sw_sync <= r_sw_meta;
            if (r_sw_sync != r_sw_cand) begin
                r_sw_cand <= r_sw_sync;
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DW'(DEB_CYCLES - 1)) begin
                r_sw_deb <= r_sw_cand;
            end else begin
                r_deb_cnt <= r_deb_cnt + DW'(1);
            end
            r_pre <= w_pre_wrap ? '0 : r_pre + PW'(1);
            if (w_pre_wrap)
                r_dig <= w_frame_end ? 3'd0 : r_dig + 3'd1;
            // r_load marks the first cycle out of reset so live data appears without waiting a frame
            if (w_frame_end || r_load)
                r_snap <= w_sel;
            r_load <= 1'b0;
            En     <= ~(6'd1 << r_dig);
            Segs   <= SEG_LUT[{w_nib, 3'b000} +: 8];
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized bench for seg_scan_ctrl with a cycle-count based
// reference model plus hand-computed frame expectations.
module tb_seg_scan_ctrl;
    localparam int SD  = 4;
    localparam int DEB = 3;
    localparam int FR  = 6 * SD;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [5:0]  Switch;
    logic [31:0] PC, Instr, ALU_Result, Mem_Data;
    logic [7:0]  Segs;
    logic [5:0]  En;

    int checks = 0;
    int failures = 0;
    logic mon = 1'b0;

    seg_scan_ctrl #(.SCAN_DIV(SD), .DEB_CYCLES(DEB)) dut (
        .CLK(CLK), .Reset(Reset), .Switch(Switch), .PC(PC), .Instr(Instr),
        .ALU_Result(ALU_Result), .Mem_Data(Mem_Data), .Segs(Segs), .En(En)
    );

    always #5 CLK = ~CLK;

    // model: k counts edges since reset release; sw_hist[i] is Switch[2:0] sampled i+1 edges ago
    logic [7:0]  lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    int          k = 0;
    logic [23:0] snap_m;
    logic [2:0]  deb_m;
    logic [2:0]  sw_hist [0:DEB+1];
    logic [5:0]  exp_en;
    logic [7:0]  exp_segs;

    function automatic logic [23:0] pick(input logic [2:0] s);
        logic [31:0] v;
        v = s[1:0] == 2'd0 ? PC : s[1:0] == 2'd1 ? Instr : s[1:0] == 2'd2 ? ALU_Result : Mem_Data;
        return s[2] ? v[31:8] : v[23:0];
    endfunction

    function automatic logic stable();
        for (int i = 2; i <= DEB + 1; i++)
            if (sw_hist[i] != sw_hist[1]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge CLK) begin
        if (Reset) begin
            k        <= 0;
            snap_m   <= '0;
            deb_m    <= '0;
            exp_en   <= 6'h3F;
            exp_segs <= 8'hFF;
            for (int i = 0; i <= DEB + 1; i++) sw_hist[i] <= '0;
        end else begin
            k        <= k + 1;
            exp_en   <= ~(6'd1 << ((k / SD) % 6));
            exp_segs <= lut[snap_m[4 * ((k / SD) % 6) +: 4]];
            if (k == 0 || (k + 1) % FR == 0) snap_m <= pick(deb_m);
            if (stable()) deb_m <= sw_hist[1];
            sw_hist[0] <= Switch[2:0];
            for (int i = 1; i <= DEB + 1; i++) sw_hist[i] <= sw_hist[i-1];
        end
    end

    always @(negedge CLK) begin
        if (mon) begin
            checks++;
            if (En !== exp_en || Segs !== exp_segs) begin
                failures++;
                $display("FAIL model k=%0d: En=%b Segs=%h expected En=%b Segs=%h", k, En, Segs, exp_en, exp_segs);
            end
            checks++;
            if ($countones(~En) > 1 || Segs[7] !== 1'b1) begin
                failures++;
                $display("FAIL onehot k=%0d: En=%b Segs=%h expected <=1 low enable and dp=1", k, En, Segs);
            end
        end
    end

    task automatic lit(input string nm, input logic [5:0] en, input logic [7:0] sg);
        checks++;
        if (En !== en || Segs !== sg) begin
            failures++;
            $display("FAIL %s k=%0d: En=%b Segs=%h expected En=%b Segs=%h", nm, k, En, Segs, en, sg);
        end
    endtask

    task automatic lit_frame(input string nm, input logic [47:0] segs6);
        for (int j = 0; j < FR; j++) begin
            lit(nm, ~(6'd1 << (j / SD)), segs6[8 * (j / SD) +: 8]);
            @(negedge CLK);
        end
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 100 && !(k % FR == 1 && k > 1); i++) @(negedge CLK);
    endtask

    task automatic drive_alu();
        ALU_Result = ((k + 1) % FR == 0) ? 32'h77FEDCBA : $urandom;
        @(negedge CLK);
    endtask

    initial begin
        int cnt;
        Reset = 1'b1;
        Switch = '0;
        PC = 32'h00123456;
        Instr = 32'h98765432;
        ALU_Result = 32'h0;
        Mem_Data = 32'h13579BDF;
        @(negedge CLK);
        mon = 1'b1;
        repeat (2) @(negedge CLK);
        lit("reset", 6'h3F, 8'hFF);
        Reset = 1'b0;
        @(negedge CLK);
        lit("first", 6'h3E, 8'hC0);
        for (int j = 1; j < FR; j++) begin
            logic [47:0] p;
            p = 48'hF9_A4_B0_99_92_82;
            @(negedge CLK);
            lit("scan", ~(6'd1 << (j / SD)), p[8 * (j / SD) +: 8]);
        end
        @(negedge CLK);
        PC = 32'hABCDEF01;
        Switch = 6'b000100;
        repeat (10) @(negedge CLK);
        wait_frame();
        lit_frame("half", 48'h88_83_C6_A1_86_8E);
        Switch = 6'b000101;
        repeat (2) @(negedge CLK);
        Switch = 6'b000100;
        wait_frame();
        lit_frame("pulse", 48'h88_83_C6_A1_86_8E);
        Switch = 6'b000101;
        lit_frame("hold_old", 48'h88_83_C6_A1_86_8E);
        lit_frame("instr", 48'h90_80_F8_82_92_99);
        Switch = 6'b000010;
        cnt = 0;
        do begin
            drive_alu();
            cnt++;
        end while (!(cnt > 10 && k % FR == 1));
        fork
            lit_frame("alu", 48'h8E_86_A1_C6_83_88);
            repeat (FR) drive_alu();
        join
        while (k % FR != 14) @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        lit("mid_reset", 6'h3F, 8'hFF);
        Reset = 1'b0;
        @(negedge CLK);
        lit("restart", 6'h3E, 8'hC0);
        for (int j = 2; j <= 4; j++) begin
            @(negedge CLK);
            lit("restart_d0", 6'h3E, 8'hF9);
        end
        @(negedge CLK);
        lit("restart_d1", 6'h3D, 8'hC0);
        for (int j = 0; j < 10 * FR; j++) begin
            PC = $urandom;
            Instr = $urandom;
            ALU_Result = $urandom;
            Mem_Data = $urandom;
            if ($urandom_range(0, 5) == 0) Switch = 6'($urandom);
            @(negedge CLK);
        end
        mon = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Display scheduler for the single-cycle CPU board. Shares the board's six-digit seven-segment display (`Segs`/`En`) between four CPU observation sources, selected by the debounced `Switch` inputs. It time-multiplexes the digits, decodes hex nibbles, and snapshots the selected value once per scan frame so a digit never shows a mix of two values. It sits between the CPU core and the board pins inside `Single_Cpu_board`.

## Interface
Parameters:
- `SCAN_DIV`, 50000: `CLK` cycles each digit stays lit; legal range ≥2.
- `DEB_CYCLES`, 20000: consecutive stable synchronized samples required to accept a `Switch` change; legal range ≥1.

Ports:
- `CLK` in 1: the single clock; every flop is on its rising edge.
- `Reset` in 1: synchronous, active-high.
- `Switch` in 6: raw board switches, asynchronous.
  - [1:0] select the source: 00 `PC`, 01 `Instr`, 10 `ALU_Result`, 11 `Mem_Data`.
  - [2] selects the half: 0 shows bits [23:0], 1 shows bits [31:8].
  - [5:3] are ignored by this block.
- `PC` in 32: current program counter.
- `Instr` in 32: current instruction.
- `ALU_Result` in 32: ALU output.
- `Mem_Data` in 32: data-memory read data.
- `Segs` out 8: active-low segments {dp,g,f,e,d,c,b,a}.
- `En` out 6: active-low digit enables; `En[i]` lights digit i, and digit 0 is rightmost.

## Operation
Switch synchronization and debounce:
- Two flops synchronize `Switch` into `sw_sync`.
- The candidate register `sw_cand` and stable counter `deb_cnt` track `sw_sync`:
  - If `sw_sync` ≠ `sw_cand`: load `sw_cand` ← `sw_sync` and clear `deb_cnt`.
  - Otherwise, if `deb_cnt` = `DEB_CYCLES`−1: load `sw_deb` ← `sw_cand`.
  - Otherwise: increment `deb_cnt`. `deb_cnt` saturates and does not wrap.

Scan scheduler:
- Prescaler `pre` counts 0..`SCAN_DIV`−1 and then wraps to 0.
- When `pre` wraps, digit index `dig` advances 0→1→…→5→0.
- `dig` values 6 and 7 are never reached.

Snapshot:
- The 24-bit `snap` register is loaded from the `sw_deb`-selected source and half:
  - in the cycle `dig` goes 5→0;
  - in the first cycle after `Reset` deasserts.
- `snap` holds its value at all other times.
- A `sw_deb` change is therefore visible from the next frame onward, never mid-frame.

Output stage (registered):
- `En` ← one-hot-low of `dig`.
- `Segs` ← hex decode of `snap[4*dig+3 : 4*dig]`, with dp = 1 (off).
- Decode values (hex): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.

Reset (any cycle, including mid-frame or mid-debounce):
- Next edge sets `pre`=0, `dig`=0, `snap`=0, `sw_sync`=0, `sw_cand`=0, `sw_deb`=0, `deb_cnt`=0.
- Outputs go to `En`=6'b111111 and `Segs`=8'hFF (all dark).

## Timing
- While `Reset` is high, outputs remain all dark.
- Outputs one edge after `Reset` deasserts: `En`=6'b111110 and `Segs` = decode(0) = C0. The first snapshot of live data is loaded on that same edge.
- Outputs one edge later (the second edge after deassertion): digit 0 shows nibble 0 of the loaded snapshot.
- Output latency: `En`/`Segs` lag `dig`/`snap` by exactly 1 cycle.
- Each digit is lit for exactly `SCAN_DIV` consecutive cycles; a frame is 6×`SCAN_DIV` cycles.
- Never more than one `En` bit is low; the enable transition is glitch-free because both outputs are registered.
- Switch latency:
  - A change held stable updates `sw_deb` 2 + `DEB_CYCLES` cycles after it reaches the `Switch` input (2 sync flops).
  - The display then reflects it at the next 5→0 frame boundary.
- A pulse shorter than `DEB_CYCLES` synchronized cycles never reaches `sw_deb`.
- Source inputs may change every cycle. Only the value present on the snapshot edge is displayed.

## Test plan
Bench parameters for all scenarios: `SCAN_DIV`=4, `DEB_CYCLES`=3.

1. Reset, then release, with `Switch`=0 and `PC`=32'h00123456:
   - the first post-reset cycle shows `En`=111110, `Segs`=C0;
   - then digits 0..5 show 6,5,4,3,2,1 (82,92,99,B0,A4,F9), each for 4 cycles, with `En` rotating 111110→111101→…→011111→111110.
2. Set `Switch`=6'b000100 with `PC`=32'hABCDEF01 and let it debounce:
   - the next frame shows digits 0..5 = F,E,d,C,b,A (8E,86,A1,C6,83,88).
3. Pulse `Switch[0]` high for 2 cycles, with `Instr` ≠ `PC`:
   - `sw_deb` stays 0 and `PC` remains displayed.
   - Then hold `Switch[0]` high: `sw_deb` updates after 5 cycles, and `Instr` appears only from the next digit-0 frame start.
4. Change `ALU_Result` every cycle mid-frame while it is selected:
   - all six digits of the frame match the value sampled at the 5→0 edge.
5. Assert `Reset` for 1 cycle while digit 3 is lit:
   - the next edge gives `En`=111111 and `Segs`=FF;
   - scanning then restarts at digit 0 with `pre`=0.
6. Run 10 full frames continuously:
   - the assertion check holds every cycle: at most one `En` bit is low, and `Segs[7]`=1.
